// File: rtl/ubx_pkg.sv
// Shared UBX protocol constants, NAV message layouts and parser state encoding.
package ubx_pkg;

  localparam logic [7:0] SyncChar1 = 8'hB5;
  localparam logic [7:0] SyncChar2 = 8'h62;

  localparam logic [7:0] ClsNav    = 8'h01;
  localparam logic [7:0] IdPosllh  = 8'h02;
  localparam logic [7:0] IdVelned  = 8'h12;

  localparam logic [15:0] LenPosllh = 16'd28;
  localparam logic [15:0] LenVelned = 16'd36;

  localparam logic [15:0] OffItow    = 16'd0;
  localparam logic [15:0] OffLon     = 16'd4;
  localparam logic [15:0] OffLat     = 16'd8;
  localparam logic [15:0] OffHeight  = 16'd12;
  localparam logic [15:0] OffGspeed  = 16'd20;
  localparam logic [15:0] OffHeading = 16'd24;

  typedef enum logic [3:0] {
    StIdle,
    StSync2,
    StClass,
    StId,
    StLenL,
    StLenH,
    StPayload,
    StCkA,
    StCkB
  } state_e;

  // True when payload offset falls inside the 4-byte word starting at base.
  function automatic logic field_hit(input logic [15:0] off, input logic [15:0] base);
    return (off >= base) && (off < base + 16'd4);
  endfunction

endpackage

// File: rtl/ubx_fletcher.sv
// Fletcher-8 accumulator over the UBX class/id/length/payload bytes.
module ubx_fletcher (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] ck_a,
  output logic [7:0] ck_b
);

  logic [7:0] ck_a_q, ck_b_q;
  logic [7:0] ck_a_next;

  assign ck_a_next = ck_a_q + data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_a_q <= 8'h00;
      ck_b_q <= 8'h00;
    end else if (clr) begin
      ck_a_q <= 8'h00;
      ck_b_q <= 8'h00;
    end else if (en) begin
      ck_a_q <= ck_a_next;
      ck_b_q <= ck_b_q + ck_a_next;
    end
  end

  assign ck_a = ck_a_q;
  assign ck_b = ck_b_q;

endmodule

// File: rtl/ubx_nav_parser.sv
// UBX byte-stream parser extracting NAV-POSLLH and NAV-VELNED fields.
// Optional rejected-frame counter port err_cnt is built when UBX_STATS_EN is defined.
module ubx_nav_parser
  import ubx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_new,
  output logic [31:0] itow,
  output logic [31:0] lon,
  output logic [31:0] lat,
  output logic [31:0] height,
  output logic [31:0] gspeed,
  output logic [31:0] heading,
  output logic        pos_valid,
  output logic        vel_valid,
  output logic        frame_err
`ifdef UBX_STATS_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned OffW = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0]     MaxLen = 16'(MAX_PAYLOAD);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC);

  state_e state_q, state_d;
  logic [7:0]      cls_q, cls_d, id_q, id_d;
  logic [15:0]     len_q, len_d;
  logic [OffW-1:0] off_q, off_d;
  logic [TmoW-1:0] tmo_q;
  logic            is_pos_q, is_pos_d, is_vel_q, is_vel_d, bad_len_q, bad_len_d;
  logic            ck_a_ok_q, ck_a_ok_d;
  logic            ck_clr, ck_en;
  logic [7:0]      ck_a, ck_b;
  logic            upd_pos, upd_vel, err_d;
  logic            pos_id, vel_id;
  logic [15:0]     off16;

  logic [31:0] sh_itow, sh_lon, sh_lat, sh_height, sh_gspeed, sh_heading;

  assign off16  = 16'(off_q);
  assign pos_id = (cls_q == ClsNav) && (id_q == IdPosllh);
  assign vel_id = (cls_q == ClsNav) && (id_q == IdVelned);

  ubx_fletcher u_fletcher (
    .clk  (clk),
    .rst  (rst),
    .clr  (ck_clr),
    .en   (ck_en),
    .data (rx_data),
    .ck_a (ck_a),
    .ck_b (ck_b)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    id_d      = id_q;
    len_d     = len_q;
    off_d     = off_q;
    is_pos_d  = is_pos_q;
    is_vel_d  = is_vel_q;
    bad_len_d = bad_len_q;
    ck_a_ok_d = ck_a_ok_q;
    ck_clr    = 1'b0;
    ck_en     = 1'b0;
    upd_pos   = 1'b0;
    upd_vel   = 1'b0;
    err_d     = 1'b0;
    if (rx_new) begin
      unique case (state_q)
        StIdle: if (rx_data == SyncChar1) state_d = StSync2;
        StSync2: begin
          if (rx_data == SyncChar2) begin
            state_d = StClass;
            ck_clr  = 1'b1;
          end else if (rx_data != SyncChar1) begin
            state_d = StIdle;
          end
        end
        StClass: begin
          cls_d   = rx_data;
          ck_en   = 1'b1;
          state_d = StId;
        end
        StId: begin
          id_d    = rx_data;
          ck_en   = 1'b1;
          state_d = StLenL;
        end
        StLenL: begin
          len_d   = {8'h00, rx_data};
          ck_en   = 1'b1;
          state_d = StLenH;
        end
        StLenH: begin
          len_d     = {rx_data, len_q[7:0]};
          ck_en     = 1'b1;
          off_d     = '0;
          is_pos_d  = pos_id && (len_d == LenPosllh);
          is_vel_d  = vel_id && (len_d == LenVelned);
          bad_len_d = (pos_id && (len_d != LenPosllh)) || (vel_id && (len_d != LenVelned));
          if (len_d > MaxLen) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (len_d == 16'd0) begin
            state_d = StCkA;
          end else begin
            state_d = StPayload;
          end
        end
        StPayload: begin
          ck_en = 1'b1;
          off_d = off_q + 1'b1;
          if (off16 == len_q - 16'd1) state_d = StCkA;
        end
        StCkA: begin
          ck_a_ok_d = (rx_data == ck_a);
          state_d   = StCkB;
        end
        StCkB: begin
          state_d = StIdle;
          if (bad_len_q) begin
            err_d = 1'b1;
          end else if (is_pos_q || is_vel_q) begin
            if (ck_a_ok_q && (rx_data == ck_b)) begin
              upd_pos = is_pos_q;
              upd_vel = is_vel_q;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end else if ((state_q != StIdle) && (tmo_q == TmoMax)) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cls_q     <= 8'h00;
      id_q      <= 8'h00;
      len_q     <= 16'h0000;
      off_q     <= '0;
      is_pos_q  <= 1'b0;
      is_vel_q  <= 1'b0;
      bad_len_q <= 1'b0;
      ck_a_ok_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      id_q      <= id_d;
      len_q     <= len_d;
      off_q     <= off_d;
      is_pos_q  <= is_pos_d;
      is_vel_q  <= is_vel_d;
      bad_len_q <= bad_len_d;
      ck_a_ok_q <= ck_a_ok_d;
      if ((state_q == StIdle) || rx_new) tmo_q <= '0;
      else if (tmo_q != TmoMax)          tmo_q <= tmo_q + 1'b1;
    end
  end

  // Payload bytes land only in shadows; outputs change atomically on a good checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_itow    <= '0;
      sh_lon     <= '0;
      sh_lat     <= '0;
      sh_height  <= '0;
      sh_gspeed  <= '0;
      sh_heading <= '0;
    end else if (rx_new && (state_q == StPayload)) begin
      if (is_pos_q) begin
        if (field_hit(off16, OffItow))   sh_itow[{off_q[1:0], 3'b000} +: 8]   <= rx_data;
        if (field_hit(off16, OffLon))    sh_lon[{off_q[1:0], 3'b000} +: 8]    <= rx_data;
        if (field_hit(off16, OffLat))    sh_lat[{off_q[1:0], 3'b000} +: 8]    <= rx_data;
        if (field_hit(off16, OffHeight)) sh_height[{off_q[1:0], 3'b000} +: 8] <= rx_data;
      end
      if (is_vel_q) begin
        if (field_hit(off16, OffGspeed))  sh_gspeed[{off_q[1:0], 3'b000} +: 8]  <= rx_data;
        if (field_hit(off16, OffHeading)) sh_heading[{off_q[1:0], 3'b000} +: 8] <= rx_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      itow      <= '0;
      lon       <= '0;
      lat       <= '0;
      height    <= '0;
      gspeed    <= '0;
      heading   <= '0;
      pos_valid <= 1'b0;
      vel_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pos_valid <= upd_pos;
      vel_valid <= upd_vel;
      frame_err <= err_d;
      if (upd_pos) begin
        itow   <= sh_itow;
        lon    <= sh_lon;
        lat    <= sh_lat;
        height <= sh_height;
      end
      if (upd_vel) begin
        gspeed  <= sh_gspeed;
        heading <= sh_heading;
      end
    end
  end

`ifdef UBX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             err_cnt <= 16'h0000;
    else if (err_d && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ubx_nav_parser.sv
// Scoreboard bench for ubx_nav_parser: frame-level reference model feeds an expectation
// queue that an independent monitor drains on every pos_valid/vel_valid/frame_err pulse.
module tb_ubx_nav_parser;

  localparam int MAXP = 64;
  localparam int TMO  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_new;
  logic [31:0] itow, lon, lat, height, gspeed, heading;
  logic        pos_valid, vel_valid, frame_err;
`ifdef UBX_STATS_EN
  logic [15:0] err_cnt;
`endif

  ubx_nav_parser #(
    .MAX_PAYLOAD (MAXP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_new    (rx_new),
    .itow      (itow),
    .lon       (lon),
    .lat       (lat),
    .height    (height),
    .gspeed    (gspeed),
    .heading   (heading),
    .pos_valid (pos_valid),
    .vel_valid (vel_valid),
    .frame_err (frame_err)
`ifdef UBX_STATS_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 pos, 1 vel, 2 err
    logic [31:0] itow, lon, lat, height, gspeed, heading;
    logic [15:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: what the outputs should show after each reported event.
  logic [31:0] m_itow, m_lon, m_lat, m_height, m_gspeed, m_heading;
  logic [15:0] m_ec;
  logic [7:0]  pl[256];

  task automatic model_clear();
    m_itow = 0; m_lon = 0; m_lat = 0; m_height = 0; m_gspeed = 0; m_heading = 0; m_ec = 0;
  endtask

  task automatic push_exp(input int kind);
    exp_t e;
    if (kind == 2 && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
    e.kind = kind; e.itow = m_itow; e.lon = m_lon; e.lat = m_lat; e.height = m_height;
    e.gspeed = m_gspeed; e.heading = m_heading; e.ec = m_ec;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] le32(input int off);
    return {pl[off+3], pl[off+2], pl[off+1], pl[off]};
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_evt(input int kind);
    exp_t e;
    logic ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
      return;
    end
    e = exp_q.pop_front();
    ok = (e.kind == kind) && itow === e.itow && lon === e.lon && lat === e.lat &&
         height === e.height && gspeed === e.gspeed && heading === e.heading;
`ifdef UBX_STATS_EN
    ok = ok && (err_cnt === e.ec);
`endif
    if (!ok) begin
      errors++;
      $display("FAIL event: got kind %0d %h %h %h %h %h %h expected kind %0d %h %h %h %h %h %h",
               kind, itow, lon, lat, height, gspeed, heading,
               e.kind, e.itow, e.lon, e.lat, e.height, e.gspeed, e.heading);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (pos_valid) check_evt(0);
      if (vel_valid) check_evt(1);
      if (frame_err) check_evt(2);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_new  = 1'b1;
    @(negedge clk);
    rx_new  = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // flip: 0 intact, 1 corrupt CK_A, 2 corrupt CK_B. Payload taken from pl[].
  task automatic send_frame(input logic [7:0] cls, input logic [7:0] id, input int len,
                            input int flip, input int pre_b5);
    logic [7:0] ca, cb, hdr[4];
    logic       kpos, kvel;
    hdr[0] = cls; hdr[1] = id; hdr[2] = len[7:0]; hdr[3] = len[15:8];
    ca = 0; cb = 0;
    for (int i = 0; i < 4; i++) begin ca = ca + hdr[i]; cb = cb + ca; end
    if (len <= MAXP) for (int i = 0; i < len; i++) begin ca = ca + pl[i]; cb = cb + ca; end
    repeat (pre_b5) send_byte(8'hB5);
    send_byte(8'hB5);
    send_byte(8'h62);
    for (int i = 0; i < 3; i++) send_byte(hdr[i]);
    if (len > MAXP) begin
      push_exp(2);
      send_byte(hdr[3]);
      return;
    end
    send_byte(hdr[3]);
    for (int i = 0; i < len; i++) send_byte(pl[i]);
    send_byte(ca ^ ((flip == 1) ? 8'h01 : 8'h00));
    kpos = (cls == 8'h01) && (id == 8'h02);
    kvel = (cls == 8'h01) && (id == 8'h12);
    if (kpos || kvel) begin
      if ((kpos && len != 28) || (kvel && len != 36) || flip != 0) begin
        push_exp(2);
      end else if (kpos) begin
        m_itow = le32(0); m_lon = le32(4); m_lat = le32(8); m_height = le32(12);
        push_exp(0);
      end else begin
        m_gspeed = le32(20); m_heading = le32(24);
        push_exp(1);
      end
    end
    send_byte(cb ^ ((flip == 2) ? 8'h01 : 8'h00));
  endtask

  task automatic rand_payload(input int len);
    for (int i = 0; i < len && i < 256; i++) pl[i] = 8'($urandom);
  endtask

  task automatic set_posllh(input logic [31:0] a, b, c, d);
    rand_payload(28);
    {pl[3], pl[2], pl[1], pl[0]}     = a;
    {pl[7], pl[6], pl[5], pl[4]}     = b;
    {pl[11], pl[10], pl[9], pl[8]}   = c;
    {pl[15], pl[14], pl[13], pl[12]} = d;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic reset_mid_payload();
    set_posllh(32'hDEAD0001, 32'h1, 32'h2, 32'h3);
    send_byte(8'hB5); send_byte(8'h62); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'd28); send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(pl[i]);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_clear();
    drain();
    check_val("rst_itow", itow, 32'h0);
    check_val("rst_gspeed", gspeed, 32'h0);
`ifdef UBX_STATS_EN
    check_val("rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, len, flip;
    logic [7:0] cls, id;
    rst = 1'b1; rx_new = 1'b0; rx_data = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    check_val("reset_itow", itow, 32'h0);
    check_val("reset_lat", lat, 32'h0);
    check_val("reset_heading", heading, 32'h0);
    check_val("reset_pulses", {29'h0, pos_valid, vel_valid, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Known-good POSLLH, then same frame with corrupted CK_B.
    set_posllh(32'h00001234, 32'hF8A43210, 32'h19A2B3C4, 32'h0000C350);
    send_frame(8'h01, 8'h02, 28, 0, 0);
    drain();
    check_val("posllh_itow", itow, 32'h00001234);
    check_val("posllh_lon", lon, 32'hF8A43210);
    check_val("posllh_lat", lat, 32'h19A2B3C4);
    check_val("posllh_height", height, 32'h0000C350);
    set_posllh(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    send_frame(8'h01, 8'h02, 28, 2, 0);
    drain();
    check_val("badck_itow_held", itow, 32'h00001234);

    // VELNED.
    rand_payload(36);
    {pl[23], pl[22], pl[21], pl[20]} = 32'd1500;
    {pl[27], pl[26], pl[25], pl[24]} = 32'd9000000;
    send_frame(8'h01, 8'h12, 36, 0, 0);
    drain();
    check_val("velned_gspeed", gspeed, 32'd1500);
    check_val("velned_heading", heading, 32'd9000000);
    check_val("velned_lon_untouched", lon, 32'hF8A43210);

    // Oversize length, then a good frame; leading extra sync byte.
    send_frame(8'h0A, 8'h04, 16'h0100, 0, 0);
    set_posllh(32'hCAFE0001, 32'h5, 32'h6, 32'h7);
    send_frame(8'h01, 8'h02, 28, 0, 1);
    drain();
    check_val("after_oversize_itow", itow, 32'hCAFE0001);

    // Inter-byte timeout after LEN_L, then recovery.
    send_byte(8'hB5); send_byte(8'h62); send_byte(8'h01); send_byte(8'h02); send_byte(8'd28);
    push_exp(2);
    repeat (TMO + 5) @(negedge clk);
    set_posllh(32'hBEEF0002, 32'h8, 32'h9, 32'hA);
    send_frame(8'h01, 8'h02, 28, 0, 0);

    // Randomised frame mix.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == 8'hB5) j = 8'h00;
        send_byte(j);
      end
      k = $urandom_range(0, 6);
      flip = 0;
      case (k)
        0, 1: begin cls = 8'h01; id = 8'h02; len = 28; flip = (k == 1) ? $urandom_range(1, 2) : 0; end
        2, 3: begin cls = 8'h01; id = 8'h12; len = 36; flip = (k == 3) ? $urandom_range(1, 2) : 0; end
        4: begin
          cls = 8'h01; id = $urandom_range(0, 1) ? 8'h02 : 8'h12;
          len = $urandom_range(0, MAXP);
          if (len == 28 || len == 36) len = len + 1;
        end
        5: begin cls = 8'($urandom_range(2, 255)); id = 8'($urandom); len = $urandom_range(0, 20); end
        default: begin cls = 8'($urandom); id = 8'($urandom); len = $urandom_range(MAXP + 1, 511); end
      endcase
      rand_payload(len);
      send_frame(cls, id, len, flip, $urandom_range(0, 2));
    end
    drain();

    // Reset mid-payload, three bad-checksum frames, reset again.
    reset_mid_payload();
    for (int n = 0; n < 3; n++) begin
      set_posllh(32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom));
      send_frame(8'h01, 8'h02, 28, 1, 0);
    end
    drain();
`ifdef UBX_STATS_EN
    check_val("err_cnt_three", 32'(err_cnt), 32'd3);
`endif
    reset_mid_payload();
    set_posllh(32'h0BADF00D, 32'h1, 32'h2, 32'h3);
    send_frame(8'h01, 8'h02, 28, 0, 0);
    drain();
    check_val("final_itow", itow, 32'h0BADF00D);
    check_val("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ubx_nav_parser.md
UBX_NAV_PARSER -- requirements
Module: ubx_nav_parser

Interface
REQ-001 Parameter MAX_PAYLOAD, default 64, largest accepted payload length in bytes; longer frames are rejected.
REQ-002 Parameter TIMEOUT_CYC, default 100000, maximum idle clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  received UART byte; valid only when rx_new=1.
REQ-006 rx_new  input  1  one-cycle strobe marking one received byte.
REQ-007 itow, lon, lat, height  output  32 each  NAV-POSLLH fields (ms, 1e-7 deg, 1e-7 deg, mm).
REQ-008 gspeed, heading  output  32 each  NAV-VELNED ground speed (cm/s) and heading (1e-5 deg).
REQ-009 pos_valid, vel_valid  output  1 each  one-cycle pulse when the matching field group updates.
REQ-010 frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-011 err_cnt  output  16  saturating rejected-frame count; present only under UBX_STATS_EN.

Function
REQ-012 State machine: IDLE, SYNC2, CLASS, ID, LEN_L, LEN_H, PAYLOAD, CK_A, CK_B; states advance only on rx_new.
REQ-013 IDLE moves to SYNC2 on byte 0xB5; SYNC2 moves to CLASS on 0x62, stays on 0xB5, and returns to IDLE on any other byte.
REQ-014 Length is little-endian; LEN_H moves to PAYLOAD, or to CK_A when length is 0.
REQ-015 Length > MAX_PAYLOAD: frame_err pulse, return to IDLE on the same byte.
REQ-016 Fletcher-8 checksum: ck_a += byte and ck_b += ck_a, mod 256, over CLASS, ID, LEN_L, LEN_H and payload; both clear on entry to CLASS.
REQ-017 Payload offset counter is $clog2(MAX_PAYLOAD+1) bits, starts at 0 and increments per byte; PAYLOAD moves to CK_A after byte length-1.
REQ-018 NAV-POSLLH (class 0x01, id 0x02, length 28) captures little-endian words into shadow registers: itow at offset 0, lon at 4, lat at 8, height at 12.
REQ-019 NAV-VELNED (class 0x01, id 0x12, length 36) captures gspeed at offset 20 and heading at offset 24.
REQ-020 Known class/id with wrong length is consumed to the end and then rejected with frame_err.
REQ-021 Unknown class/id is consumed silently through CK_B; no valid pulse and no error.
REQ-022 Received CK_A/CK_B are compared with the computed values; both must match.
REQ-023 On match for a known message, the shadow registers copy to the outputs one cycle after the CK_B byte, together with the pos_valid or vel_valid pulse.
REQ-024 On mismatch, the outputs hold their values and frame_err pulses; the state returns to IDLE.
REQ-025 Outputs never show a partially updated frame; shadow registers alone absorb payload bytes.
REQ-026 The inter-byte counter resets on every rx_new; when not in IDLE and the count reaches TIMEOUT_CYC, frame_err pulses and the state returns to IDLE.
REQ-027 The inter-byte counter is held at 0 in IDLE.
REQ-028 A 0xB5 byte mid-frame is treated as data, never as resynchronisation.

Reset
REQ-029 rst asynchronously forces state IDLE and clears all outputs, shadows, checksums, counters, pulses and err_cnt to 0.
REQ-030 rst asserted mid-frame discards the frame with no frame_err pulse.

Configuration
REQ-031 With UBX_STATS_EN defined, err_cnt increments on each frame_err pulse and saturates at 0xFFFF.
REQ-032 Without UBX_STATS_EN, the err_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package ubx_pkg holds the sync bytes, class/id constants, the POSLLH/VELNED lengths, field offsets and the state enum.
REQ-034 Sub-module ubx_fletcher (clear, byte-enable, ck_a/ck_b) holds the checksum accumulator; all other logic is in ubx_nav_parser.

Verification
REQ-035 Valid POSLLH frame (itow=0x00001234, lon=0xF8A43210, lat=0x19A2B3C4, height=0x0000C350) -> one pos_valid pulse one cycle after CK_B, and the four outputs equal these values.
REQ-036 Same frame with CK_B corrupted by XOR 0x01 -> frame_err pulse, no pos_valid, and outputs unchanged from the prior values.
REQ-037 Valid VELNED frame with gspeed=1500 and heading=9000000 -> vel_valid pulse; gspeed=1500, heading=9000000; POSLLH outputs untouched.
REQ-038 Frame with class 0x0A, id 0x04, length 0x0100 (MAX_PAYLOAD=64) -> frame_err on the LEN_H byte; the next valid frame parses correctly.
REQ-039 Bytes 0xB5 0xB5 0x62 followed by a valid POSLLH body -> parsed; a stall of TIMEOUT_CYC cycles after LEN_L -> frame_err and return to IDLE.
REQ-040 Under UBX_STATS_EN, 3 bad-checksum frames -> err_cnt=3; rst pulse mid-payload -> err_cnt=0 and no frame_err pulse.
